instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Producer end of the decode interface: fetches 32-bit instruction words from instruction memory and
//  presents opcode/funct fields, plus full word and PC, to control_unit and the register-file stage.
//  Owns the PC, a single-outstanding-request memory handshake, and a small skid FIFO that decouples
//  memory latency from decode back-pressure. Supports PC redirect (branch/jump) with flush.
// PARAMETERS
//  ADDR_W      32   PC / memory address width (bits)
//  FIFO_DEPTH  2    instruction buffer entries (power of 2, >=2)
//  RESET_PC    0    PC value loaded on reset
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  rst_n        in   1       asynchronous active-low reset
//  imem_req     out  1       fetch request valid
//  imem_addr    out  ADDR_W  fetch address, word aligned ([1:0]=0)
//  imem_gnt     in   1       memory accepts request this cycle
//  imem_rvalid  in   1       read data valid
//  imem_rdata   in   32      instruction word
//  redirect     in   1       load new PC, flush buffer
//  redirect_pc  in   ADDR_W  redirect target; [1:0] ignored, forced 0
//  dec_valid    out  1       instruction available to decode
//  dec_ready    in   1       decode consumes instruction this cycle
//  dec_instr    out  32      head instruction word
//  dec_pc       out  ADDR_W  PC of head instruction
//  dec_opcode   out  6       dec_instr[31:26]
//  dec_funct    out  6       dec_instr[5:0]
// BEHAVIOUR
//  Reset (async assert, sync deassert use): PC=RESET_PC, state IDLE, FIFO empty, discard=0;
//   imem_req=0, dec_valid=0, dec_instr/dec_pc/opcode/funct=0 (outputs from empty FIFO read as 0).
//  FSM: IDLE -> REQ when (fifo_count + outstanding) < FIFO_DEPTH and no redirect this cycle.
//   REQ: imem_req=1, imem_addr=PC held stable until imem_gnt. On gnt: PC<=PC+4, -> WAIT.
//   WAIT: on imem_rvalid push {rdata, issued PC} unless discard set; -> IDLE (next req earliest
//   the cycle after rvalid). At most one request outstanding; rvalid without outstanding ignored.
//  Fetch latency: rvalid earliest 1 cycle after gnt; dec_valid asserts the cycle after the push.
//  Decode handshake: transfer when dec_valid & dec_ready; head pops; outputs change only on pop/push
//   into empty. Outputs stable while dec_valid & !dec_ready.
//  FIFO: push and pop same cycle allowed at any count incl. full; count unchanged. Pointers wrap
//   modulo FIFO_DEPTH. Push never occurs when full (guaranteed by request gating).
//  Redirect (priority over all else): FIFO flushed, PC<=redirect_pc&~3, dec_valid=0 next cycle.
//   If in REQ and gnt same cycle: gnt accepted, discard<=1, -> WAIT. If in REQ without gnt: drop
//   request, -> IDLE. If in WAIT: discard<=1 (response dropped), stay WAIT; if rvalid same cycle,
//   data dropped, -> IDLE. Pop in redirect cycle ignored. discard clears when the rvalid consumes it.
//  PC arithmetic: ADDR_W-bit, wraps 0xFFFF_FFFC -> 0x0 silently.
//  Reset mid-transaction: all state cleared; a late rvalid after reset is ignored (no outstanding).
// TESTING
//  1 Reset, gnt tied 1, rvalid 1 cycle later, rdata=0x012A4020, ready=1 -> dec_pc=0x0, opcode=0x00,
//    funct=0x20; next fetch addr 0x4; one instruction per 2-3 cycles, no gaps once steady.
//  2 dec_ready=0 for 10 cycles -> exactly FIFO_DEPTH words buffered, imem_req stays 0, dec_instr
//    stable; release -> words delivered in order PC 0x0,0x4 without loss or duplication.
//  3 imem_gnt withheld 5 cycles -> imem_req=1, imem_addr constant 0x8 throughout.
//  4 redirect_pc=0x103 while in WAIT -> pending word dropped, FIFO empty, next imem_addr=0x100,
//    first dec_pc after redirect = 0x100.
//  5 Redirect same cycle as gnt and as pop with FIFO full -> no stale word ever reaches decode.
//  6 rst_n low during WAIT, then rvalid -> no push, dec_valid=0, imem_addr=RESET_PC after release.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory handshake, redirect input and decode output.
// master = fetch unit, slave = memory/decode environment.
interface instr_fetch_unit_if #(
   parameter int unsigned ADDR_W = 32
);
   logic              imem_req;
   logic [ADDR_W-1:0] imem_addr;
   logic              imem_gnt;
   logic              imem_rvalid;
   logic [31:0]       imem_rdata;
   logic              redirect;
   logic [ADDR_W-1:0] redirect_pc;
   logic              dec_valid;
   logic              dec_ready;
   logic [31:0]       dec_instr;
   logic [ADDR_W-1:0] dec_pc;
   logic [5:0]        dec_opcode;
   logic [5:0]        dec_funct;

   modport master (
      output imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct,
      input  imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
   );

   modport slave (
      input  imem_req, imem_addr, dec_valid, dec_instr, dec_pc, dec_opcode, dec_funct,
      output imem_gnt, imem_rvalid, imem_rdata, redirect, redirect_pc, dec_ready
   );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, issues one outstanding memory request at a time and
// buffers returned words in a small skid FIFO toward decode; redirect flushes everything.
module instr_fetch_unit #(
   parameter int unsigned       ADDR_W     = 32,
   parameter int unsigned       FIFO_DEPTH = 2,
   parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
   input logic                 clk,
   input logic                 rst_n,
   instr_fetch_unit_if.master  bus
);

   localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W   = PTR_W + 1;
   localparam int unsigned INSTR_W = 32;

   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc;
   } fifo_entry_t;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] pc, pc_nxt;
   logic [ADDR_W-1:0] fetch_pc;
   logic              discard, discard_nxt;
   logic              push, pop, flush;

   fifo_entry_t       mem [FIFO_DEPTH];
   fifo_entry_t       head;
   logic [PTR_W-1:0]  rd_ptr, wr_ptr;
   logic [CNT_W-1:0]  count, count_nxt;

   // Next-state, PC and FIFO control; redirect overrides every other action.
   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      discard_nxt = discard;
      push        = 1'b0;
      pop         = 1'b0;
      flush       = 1'b0;
      if (bus.redirect) begin
         flush  = 1'b1;
         pc_nxt = bus.redirect_pc & ~ADDR_W'(3);
         case (state)
            REQ: begin
               if (bus.imem_gnt) begin
                  state_nxt   = WAIT;
                  discard_nxt = 1'b1;
               end else begin
                  state_nxt = IDLE;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  state_nxt   = IDLE;
                  discard_nxt = 1'b0;
               end else begin
                  discard_nxt = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end else begin
         pop = bus.dec_valid & bus.dec_ready;
         case (state)
            IDLE: begin
               if (count < CNT_W'(FIFO_DEPTH)) state_nxt = REQ;
            end
            REQ: begin
               if (bus.imem_gnt) begin
                  pc_nxt    = pc + ADDR_W'(4);
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               if (bus.imem_rvalid) begin
                  state_nxt = IDLE;
                  if (discard) discard_nxt = 1'b0;
                  else         push        = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
      count_nxt = flush ? '0 : count + CNT_W'(push) - CNT_W'(pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         pc            <= RESET_PC;
         fetch_pc      <= '0;
         discard       <= 1'b0;
         rd_ptr        <= '0;
         wr_ptr        <= '0;
         count         <= '0;
         bus.imem_req  <= 1'b0;
         bus.dec_valid <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         discard       <= discard_nxt;
         count         <= count_nxt;
         bus.imem_req  <= (state_nxt == REQ);
         bus.dec_valid <= (count_nxt != '0);
         if (state == REQ && bus.imem_gnt) fetch_pc <= pc;
         if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
         end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         end
      end
   end

   // Storage needs no reset: reads are masked while the buffer is empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: fetch_pc};
   end

   assign head           = mem[rd_ptr];
   assign bus.imem_addr  = pc;
   assign bus.dec_instr  = bus.dec_valid ? head.instr : '0;
   assign bus.dec_pc     = bus.dec_valid ? head.pc : '0;
   assign bus.dec_opcode = bus.dec_instr[31:26];
   assign bus.dec_funct  = bus.dec_instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a randomized memory/decode environment drives the DUT and the
// decoded stream is compared with the ideal in-order PC sequence restarting at each redirect.
module tb_instr_fetch_unit;
   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DEPTH  = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus ();

   instr_fetch_unit #(.ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .RESET_PC('0)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   int gnt_mode, ready_mode, lat_cfg;
   bit rand_redirect;
   bit out_busy;
   logic [31:0] out_addr;
   int lat_left;
   int cyc;

   logic [31:0] gnt_addr[$];
   logic [31:0] obs_pc[$];
   logic [31:0] obs_instr[$];
   logic [5:0]  obs_op[$];
   logic [5:0]  obs_fn[$];
   int          obs_cyc[$];
   int          obs_seg[$];
   int          seg;
   logic [31:0] seg_start[$];
   int multi_out, redirect_leak, hold_breaks, req_breaks, misalign;

   // Memory contents: a fixed scramble of the address; address 0 holds 0x012A4020.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h012A_4020;
   endfunction

   task automatic clear_logs(input logic [31:0] start);
      gnt_addr.delete(); obs_pc.delete(); obs_instr.delete(); obs_op.delete();
      obs_fn.delete(); obs_cyc.delete(); obs_seg.delete(); seg_start.delete();
      seg = 0;
      seg_start.push_back(start);
      multi_out = 0; redirect_leak = 0; hold_breaks = 0; req_breaks = 0; misalign = 0;
   endtask

   // Environment inputs for the coming cycle: memory responder, decode ready, random redirect.
   task automatic drive_next();
      bus.imem_rvalid = 1'b0;
      if (out_busy) begin
         lat_left--;
         if (lat_left == 0) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = mem_word(out_addr);
         end
      end
      case (gnt_mode)
         0: bus.imem_gnt = 1'b1;
         1: bus.imem_gnt = 1'($urandom_range(0, 1));
         default: bus.imem_gnt = 1'b0;
      endcase
      case (ready_mode)
         0: bus.dec_ready = 1'b1;
         1: bus.dec_ready = ($urandom_range(0, 3) != 0);
         default: bus.dec_ready = 1'b0;
      endcase
      bus.redirect = 1'b0;
      if (rand_redirect && $urandom_range(0, 19) == 0) begin
         bus.redirect = 1'b1;
         if ($urandom_range(0, 3) == 0) bus.redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
         else                           bus.redirect_pc = $urandom;
      end
   endtask

   // One clock: record what the environment saw before the edge, then observe after it.
   task automatic cycle();
      logic s_req, s_gnt, s_rv, s_dv, s_dr, s_redir, s_rst;
      logic [31:0] s_addr, s_pc, s_instr, s_rpc;
      logic [5:0] s_op, s_fn;
      s_req = bus.imem_req;   s_gnt = bus.imem_gnt;   s_rv = bus.imem_rvalid;
      s_dv = bus.dec_valid;   s_dr = bus.dec_ready;   s_redir = bus.redirect;
      s_rst = rst_n;          s_addr = bus.imem_addr; s_pc = bus.dec_pc;
      s_instr = bus.dec_instr; s_rpc = bus.redirect_pc;
      s_op = bus.dec_opcode;  s_fn = bus.dec_funct;
      if (s_rst) begin
         if (s_rv) out_busy = 1'b0;
         if (s_dv && s_dr && !s_redir) begin
            obs_pc.push_back(s_pc); obs_instr.push_back(s_instr); obs_op.push_back(s_op);
            obs_fn.push_back(s_fn); obs_cyc.push_back(cyc); obs_seg.push_back(seg);
         end
         if (s_req && s_gnt) begin
            if (out_busy) multi_out++;
            out_busy = 1'b1;
            out_addr = s_addr;
            lat_left = (lat_cfg > 0) ? lat_cfg : int'($urandom_range(1, 3));
            gnt_addr.push_back(s_addr);
         end
         if (s_redir) begin
            seg++;
            seg_start.push_back(s_rpc & ~32'h3);
         end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (s_rst && rst_n) begin
         if (s_redir && bus.dec_valid) redirect_leak++;
         if (s_dv && !s_dr && !s_redir &&
             (bus.dec_valid !== 1'b1 || bus.dec_pc !== s_pc || bus.dec_instr !== s_instr)) hold_breaks++;
         if (s_req && !s_gnt && !s_redir &&
             (bus.imem_req !== 1'b1 || bus.imem_addr !== s_addr)) req_breaks++;
         if (bus.imem_req && bus.imem_addr[1:0] != 2'b00) misalign++;
      end
      drive_next();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_gnt = 1'b0;
      bus.imem_rvalid = 1'b0; bus.imem_rdata = '0; bus.dec_ready = 1'b0;
      out_busy = 1'b0; rand_redirect = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc = 0;
      clear_logs('0);
      drive_next();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      bus.redirect = 1'b0; bus.redirect_pc = '0; bus.imem_gnt = 1'b1;
      bus.imem_rvalid = 1'b1; bus.imem_rdata = 32'hFFFF_FFFF; bus.dec_ready = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", bus.imem_req); end
      checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.dec_valid); end
      checks++; if (bus.dec_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", bus.dec_instr); end
      checks++; if (bus.dec_pc !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", bus.dec_pc); end
      checks++; if (bus.dec_opcode !== 6'h0 || bus.dec_funct !== 6'h0) begin failures++; $display("FAIL reset_fields got=%h/%h exp=0/0", bus.dec_opcode, bus.dec_funct); end
      checks++; if (bus.imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", bus.imem_addr); end
   endtask

   task automatic test_basic();
      gnt_mode = 0; ready_mode = 0; lat_cfg = 1;
      do_reset();
      repeat (32) cycle();
      checks++; if (obs_pc.size() < 9 || obs_pc.size() > 16) begin failures++; $display("FAIL basic_rate got=%0d exp=9..16", obs_pc.size()); end
      if (obs_pc.size() > 0) begin
         checks++; if (obs_pc[0] !== 32'h0) begin failures++; $display("FAIL basic_first_pc got=%h exp=0", obs_pc[0]); end
         checks++; if (obs_instr[0] !== 32'h012A_4020) begin failures++; $display("FAIL basic_first_instr got=%h exp=012a4020", obs_instr[0]); end
         checks++; if (obs_op[0] !== 6'h00 || obs_fn[0] !== 6'h20) begin failures++; $display("FAIL basic_fields got=%h/%h exp=00/20", obs_op[0], obs_fn[0]); end
      end
      checks++; if (gnt_addr.size() < 2) begin failures++; $display("FAIL basic_grants got=%0d exp>=2", gnt_addr.size()); end
      else if (gnt_addr[1] !== 32'h4) begin failures++; $display("FAIL basic_second_addr got=%h exp=4", gnt_addr[1]); end
      for (int i = 1; i < obs_pc.size(); i++) begin
         checks++; if (obs_pc[i] !== 32'(4 * i) || obs_instr[i] !== mem_word(32'(4 * i))) begin failures++; $display("FAIL basic_order[%0d] got=%h/%h exp=%h/%h", i, obs_pc[i], obs_instr[i], 32'(4 * i), mem_word(32'(4 * i))); end
         checks++; if (obs_cyc[i] - obs_cyc[i-1] > 3) begin failures++; $display("FAIL basic_gap[%0d] got=%0d exp<=3", i, obs_cyc[i] - obs_cyc[i-1]); end
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] held;
      gnt_mode = 0; ready_mode = 2; lat_cfg = 1;
      do_reset();
      repeat (10) cycle();
      checks++; if (gnt_addr.size() != DEPTH) begin failures++; $display("FAIL bp_buffered got=%0d exp=%0d", gnt_addr.size(), DEPTH); end
      checks++; if (bus.dec_valid !== 1'b1 || bus.dec_pc !== 32'h0) begin failures++; $display("FAIL bp_head got=%b/%h exp=1/0", bus.dec_valid, bus.dec_pc); end
      held = bus.dec_instr;
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++; if (bus.imem_req !== 1'b0) begin failures++; $display("FAIL bp_req_idle got=%b exp=0", bus.imem_req); end
         checks++; if (bus.dec_instr !== held) begin failures++; $display("FAIL bp_stable got=%h exp=%h", bus.dec_instr, held); end
      end
      ready_mode = 0; bus.dec_ready = 1'b1;
      repeat (20) cycle();
      checks++; if (obs_pc.size() < 4) begin failures++; $display("FAIL bp_drain got=%0d exp>=4", obs_pc.size()); end
      for (int i = 0; i < obs_pc.size(); i++) begin
         checks++; if (obs_pc[i] !== 32'(4 * i) || obs_instr[i] !== mem_word(32'(4 * i))) begin failures++; $display("FAIL bp_order[%0d] got=%h/%h exp=%h", i, obs_pc[i], obs_instr[i], 32'(4 * i)); end
      end
   endtask

   task automatic test_gnt_stall();
      gnt_mode = 0; ready_mode = 0; lat_cfg = 1;
      do_reset();
      for (int i = 0; i < 40 && gnt_addr.size() < 2; i++) cycle();
      checks++; if (gnt_addr.size() != 2) begin failures++; $display("FAIL stall_setup got=%0d exp=2", gnt_addr.size()); end
      gnt_mode = 2; bus.imem_gnt = 1'b0;
      for (int i = 0; i < 20 && !bus.imem_req; i++) cycle();
      checks++; if (bus.imem_req !== 1'b1) begin failures++; $display("FAIL stall_req_timeout got=%b exp=1", bus.imem_req); end
      for (int i = 0; i < 5; i++) begin
         cycle();
         checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h8) begin failures++; $display("FAIL stall_hold got=%b/%h exp=1/8", bus.imem_req, bus.imem_addr); end
      end
      gnt_mode = 0; bus.imem_gnt = 1'b1;
      for (int i = 0; i < 10 && gnt_addr.size() < 3; i++) cycle();
      checks++; if (gnt_addr.size() < 3) begin failures++; $display("FAIL stall_release got=%0d exp=3", gnt_addr.size()); end
      else if (gnt_addr[2] !== 32'h8) begin failures++; $display("FAIL stall_addr got=%h exp=8", gnt_addr[2]); end
   endtask

   task automatic test_redirect_wait();
      gnt_mode = 0; ready_mode = 0; lat_cfg = 4;
      do_reset();
      for (int i = 0; i < 10 && gnt_addr.size() < 1; i++) cycle();
      bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
      cycle();
      checks++; if (bus.dec_valid !== 1'b0 || bus.imem_req !== 1'b0) begin failures++; $display("FAIL rw_after got=%b/%b exp=0/0", bus.dec_valid, bus.imem_req); end
      for (int i = 0; i < 40 && gnt_addr.size() < 2; i++) cycle();
      checks++; if (gnt_addr.size() < 2) begin failures++; $display("FAIL rw_refetch got=%0d exp=2", gnt_addr.size()); end
      else if (gnt_addr[1] !== 32'h100) begin failures++; $display("FAIL rw_addr got=%h exp=100", gnt_addr[1]); end
      for (int i = 0; i < 40 && obs_pc.size() < 1; i++) cycle();
      checks++; if (obs_pc.size() < 1) begin failures++; $display("FAIL rw_no_delivery got=0 exp=1"); end
      else if (obs_pc[0] !== 32'h100 || obs_instr[0] !== mem_word(32'h100)) begin failures++; $display("FAIL rw_first got=%h/%h exp=100/%h", obs_pc[0], obs_instr[0], mem_word(32'h100)); end
   endtask

   task automatic test_redirect_collision();
      gnt_mode = 0; ready_mode = 2; lat_cfg = 1;
      do_reset();
      repeat (10) cycle();
      checks++; if (bus.dec_valid !== 1'b1 || gnt_addr.size() != DEPTH) begin failures++; $display("FAIL rc_full got=%b/%0d exp=1/%0d", bus.dec_valid, gnt_addr.size(), DEPTH); end
      ready_mode = 0; bus.dec_ready = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h200;
      cycle();
      checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rc_flush got=%b exp=0", bus.dec_valid); end
      clear_logs(32'h200);
      for (int i = 0; i < 10 && !bus.imem_req; i++) cycle();
      bus.redirect = 1'b1; bus.redirect_pc = 32'h30E;
      cycle();
      checks++; if (gnt_addr.size() != 1 || gnt_addr[0] !== 32'h200) begin failures++; $display("FAIL rc_gnt_collide got=%0d exp=1 grant at 200", gnt_addr.size()); end
      clear_logs(32'h30C);
      repeat (30) cycle();
      checks++; if (obs_pc.size() < 5) begin failures++; $display("FAIL rc_delivery got=%0d exp>=5", obs_pc.size()); end
      for (int i = 0; i < obs_pc.size(); i++) begin
         checks++; if (obs_pc[i] !== 32'h30C + 32'(4 * i) || obs_instr[i] !== mem_word(32'h30C + 32'(4 * i))) begin failures++; $display("FAIL rc_order[%0d] got=%h/%h exp=%h", i, obs_pc[i], obs_instr[i], 32'h30C + 32'(4 * i)); end
      end
   endtask

   task automatic test_pc_wrap();
      gnt_mode = 0; ready_mode = 0; lat_cfg = 1;
      do_reset();
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFF9;
      cycle();
      clear_logs(32'hFFFF_FFF8);
      repeat (20) cycle();
      checks++; if (obs_pc.size() < 3) begin failures++; $display("FAIL wrap_count got=%0d exp>=3", obs_pc.size()); end
      else if (obs_pc[2] !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=0", obs_pc[2]); end
      for (int i = 0; i < obs_pc.size(); i++) begin
         checks++; if (obs_pc[i] !== 32'hFFFF_FFF8 + 32'(4 * i) || obs_instr[i] !== mem_word(32'hFFFF_FFF8 + 32'(4 * i))) begin failures++; $display("FAIL wrap_order[%0d] got=%h exp=%h", i, obs_pc[i], 32'hFFFF_FFF8 + 32'(4 * i)); end
      end
   endtask

   task automatic test_reset_mid();
      gnt_mode = 0; ready_mode = 0; lat_cfg = 3;
      do_reset();
      for (int i = 0; i < 10 && gnt_addr.size() < 1; i++) cycle();
      rst_n = 1'b0;
      #1;
      checks++; if (bus.imem_req !== 1'b0 || bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rm_async got=%b/%b exp=0/0", bus.imem_req, bus.dec_valid); end
      cycle();
      cycle();
      rst_n = 1'b1;
      bus.imem_rdata = 32'hDEAD_BEEF;
      checks++; if (bus.imem_rvalid !== 1'b1) begin failures++; $display("FAIL rm_late_rvalid_setup got=%b exp=1", bus.imem_rvalid); end
      cycle();
      checks++; if (bus.dec_valid !== 1'b0) begin failures++; $display("FAIL rm_no_push got=%b exp=0", bus.dec_valid); end
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin failures++; $display("FAIL rm_restart got=%b/%h exp=1/0", bus.imem_req, bus.imem_addr); end
      clear_logs('0);
      repeat (15) cycle();
      checks++; if (obs_pc.size() < 2) begin failures++; $display("FAIL rm_delivery got=%0d exp>=2", obs_pc.size()); end
      for (int i = 0; i < obs_pc.size(); i++) begin
         checks++; if (obs_pc[i] !== 32'(4 * i) || obs_instr[i] !== mem_word(32'(4 * i))) begin failures++; $display("FAIL rm_order[%0d] got=%h/%h exp=%h/%h", i, obs_pc[i], obs_instr[i], 32'(4 * i), mem_word(32'(4 * i))); end
      end
   endtask

   task automatic test_random();
      logic [31:0] exp_pc, w;
      gnt_mode = 1; ready_mode = 1; lat_cfg = 0;
      do_reset();
      rand_redirect = 1'b1;
      repeat (3000) cycle();
      rand_redirect = 1'b0; gnt_mode = 0; ready_mode = 0;
      repeat (20) cycle();
      checks++; if (obs_pc.size() < 100) begin failures++; $display("FAIL rand_throughput got=%0d exp>=100", obs_pc.size()); end
      exp_pc = '0;
      for (int i = 0; i < obs_pc.size(); i++) begin
         if (i == 0 || obs_seg[i] != obs_seg[i-1]) exp_pc = seg_start[obs_seg[i]];
         w = mem_word(exp_pc);
         checks++; if (obs_pc[i] !== exp_pc || obs_instr[i] !== w) begin failures++; $display("FAIL rand_stream[%0d] got=%h/%h exp=%h/%h", i, obs_pc[i], obs_instr[i], exp_pc, w); end
         checks++; if (obs_op[i] !== w[31:26] || obs_fn[i] !== w[5:0]) begin failures++; $display("FAIL rand_fields[%0d] got=%h/%h exp=%h/%h", i, obs_op[i], obs_fn[i], w[31:26], w[5:0]); end
         exp_pc = exp_pc + 32'h4;
      end
      checks++; if (multi_out != 0) begin failures++; $display("FAIL rand_outstanding got=%0d exp=0", multi_out); end
      checks++; if (redirect_leak != 0) begin failures++; $display("FAIL rand_redirect_valid got=%0d exp=0", redirect_leak); end
      checks++; if (hold_breaks != 0) begin failures++; $display("FAIL rand_hold got=%0d exp=0", hold_breaks); end
      checks++; if (req_breaks != 0) begin failures++; $display("FAIL rand_req_hold got=%0d exp=0", req_breaks); end
      checks++; if (misalign != 0) begin failures++; $display("FAIL rand_align got=%0d exp=0", misalign); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_gnt_stall();
      test_redirect_wait();
      test_redirect_collision();
      test_pc_wrap();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
